alu_seq_acc: RTL and testbench

- Parametrised successor to the team's 8-bit accumulator ALU.
- Same 16-opcode set, but with WIDTH-generic datapath, valid/ready input handshake, registered status flags and a multi-cycle restoring divider in place of a combinational divide.
- Sits between the instruction sequencer (producer of op/a/b) and the result/flag register file.
- The result register doubles as the accumulator for accumulate opcodes.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_seq_acc_if.sv | 25 ++
 rtl/seq_divider.sv | 55 +++++
 rtl/alu_seq_acc.sv | 111 +++++++++++
 tb/tb_alu_seq_acc.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequenced accumulator ALU: opcode and FSM state encodings.
package alu_seq_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_ACC_ADD, OP_ACC_MUL, OP_MAC, OP_ROL,
    OP_ROR, OP_AND, OP_OR, OP_XOR, OP_NAND, OP_EQ, OP_GT, OP_LT
  } op_e;

  typedef enum logic {ST_IDLE, ST_DIV_RUN} state_e;

  // Comparison opcodes occupy the top of the encoding space.
  localparam op_e CMP_OP_FIRST = OP_EQ;

  function automatic logic is_cmp(input op_e op);
    return op >= CMP_OP_FIRST;
  endfunction

endpackage

// File: rtl/alu_seq_acc_if.sv
// Sequencer-to-ALU bus: valid/ready operand input plus result/flag outputs.
interface alu_seq_acc_if #(parameter int WIDTH = 8);
  import alu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             div_err;

  modport master (
    output in_valid, op, a, b,
    input  in_ready, out_valid, result, zero, carry, div_err
  );

  modport slave (
    input  in_valid, op, a, b,
    output in_ready, out_valid, result, zero, carry, div_err
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses after WIDTH steps.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   shifted, trial;

  // Dividend bits shift out of the quotient register into the partial remainder.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, div_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q  <= '0;
        quo_q  <= a;
        div_q  <= b;
        cnt_q  <= CW'(WIDTH);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/alu_seq_acc.sv
// Accumulator ALU: single-cycle ops write result/flags at acceptance; divide runs on seq_divider.
module alu_seq_acc
  import alu_seq_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] CMP_TRUE = {WIDTH{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_acc_if.slave  bus
);
  state_e           state;
  op_e              op_c;
  logic [WIDTH-1:0] a, b, acc;
  logic [WIDTH-1:0] res_c;
  logic             carry_c, err_c;
  logic [WIDTH:0]   sum_ab, sum_acc;
  logic [2*WIDTH-1:0] prod_ab, prod_acc;
  logic [2*WIDTH:0]   mac;
  logic             accept, div_start, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign op_c = op_e'(bus.op);
  assign a    = bus.a;
  assign b    = bus.b;
  assign acc  = bus.result;

  assign bus.in_ready = (state == ST_IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign div_start    = accept && (op_c == OP_DIV) && (b != '0);

  assign sum_ab   = {1'b0, a} + {1'b0, b};
  assign sum_acc  = {1'b0, acc} + {1'b0, a};
  assign prod_ab  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign prod_acc = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, a};
  assign mac      = {{(WIDTH+1){1'b0}}, acc} + {1'b0, prod_ab};

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    err_c   = 1'b0;
    case (op_c)
      OP_ADD:     begin res_c = sum_ab[WIDTH-1:0];  carry_c = sum_ab[WIDTH];  end
      OP_SUB:     begin res_c = a - b;              carry_c = (a < b);        end
      OP_MUL:     begin res_c = prod_ab[WIDTH-1:0]; carry_c = |prod_ab[2*WIDTH-1:WIDTH]; end
      // Only reaches the register file for b == 0; real quotients come from the divider.
      OP_DIV:     begin res_c = '1;                 err_c = 1'b1;             end
      OP_ACC_ADD: begin res_c = sum_acc[WIDTH-1:0]; carry_c = sum_acc[WIDTH]; end
      OP_ACC_MUL: begin res_c = prod_acc[WIDTH-1:0]; carry_c = |prod_acc[2*WIDTH-1:WIDTH]; end
      OP_MAC:     begin res_c = mac[WIDTH-1:0];     carry_c = |mac[2*WIDTH:WIDTH]; end
      OP_ROL:     res_c = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:     res_c = {a[0], a[WIDTH-1:1]};
      OP_AND:     res_c = a & b;
      OP_OR:      res_c = a | b;
      OP_XOR:     res_c = a ^ b;
      OP_NAND:    res_c = ~(a & b);
      OP_EQ:      res_c = (a == b) ? CMP_TRUE : '0;
      OP_GT:      res_c = (a > b)  ? CMP_TRUE : '0;
      OP_LT:      res_c = (a < b)  ? CMP_TRUE : '0;
    endcase
    if (is_cmp(op_c)) carry_c = 1'b0;
  end

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .a         (a),
    .b         (b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bus.result    <= '0;
      bus.zero      <= 1'b1;
      bus.carry     <= 1'b0;
      bus.div_err   <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (div_start) begin
            state <= ST_DIV_RUN;
          end else if (accept) begin
            bus.result    <= res_c;
            bus.zero      <= (res_c == '0);
            bus.carry     <= carry_c;
            bus.div_err   <= err_c;
            bus.out_valid <= 1'b1;
          end
        end
        ST_DIV_RUN: begin
          if (div_done) begin
            state         <= ST_IDLE;
            bus.result    <= div_quo;
            bus.zero      <= (div_quo == '0);
            bus.carry     <= 1'b0;
            bus.div_err   <= 1'b0;
            bus.out_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_acc.sv
// Directed bench for alu_seq_acc at WIDTH=8 with hand-computed expectations.
module tb_alu_seq_acc;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_seq_acc_if #(.WIDTH(8)) bus ();

  alu_seq_acc #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op for a single cycle; returns #1 after the accepting edge.
  task automatic issue(input op_e op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op = 4'd0;
    bus.a = 8'd0;
    bus.b = 8'd0;

    #12;
    chk("rst_result", bus.result, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_carry", bus.carry, 0);
    chk("rst_div_err", bus.div_err, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    idle_cycle();
    rst_n = 1'b1;
    idle_cycle();

    issue(OP_ADD, 8'd200, 8'd100);
    chk("add_ov", bus.out_valid, 1);
    chk("add_result", bus.result, 44);
    chk("add_carry", bus.carry, 1);
    chk("add_zero", bus.zero, 0);
    idle_cycle();
    chk("add_ov_pulse", bus.out_valid, 0);
    chk("hold_result", bus.result, 44);

    issue(OP_SUB, 8'd5, 8'd9);
    chk("sub_result", bus.result, 252);
    chk("sub_borrow", bus.carry, 1);
    issue(OP_ACC_ADD, 8'd4, 8'd0);
    chk("accadd_ov_b2b", bus.out_valid, 1);
    chk("accadd_result", bus.result, 0);
    chk("accadd_zero", bus.zero, 1);
    chk("accadd_carry", bus.carry, 1);
    idle_cycle();

    // Divide accepted at edge N; busy through N+8, result at N+9.
    issue(OP_DIV, 8'd100, 8'd7);
    chk("div_busy_ready", bus.in_ready, 0);
    chk("div_busy_ov", bus.out_valid, 0);
    for (int k = 1; k <= 8; k++) begin
      bus.in_valid = k[0];
      bus.op = OP_ADD;
      bus.a = 8'd1;
      bus.b = 8'd1;
      @(posedge clk); #1;
      chk($sformatf("div_ready_e%0d", k), bus.in_ready, 0);
      chk($sformatf("div_ov_e%0d", k), bus.out_valid, 0);
    end
    bus.in_valid = 1'b0;
    idle_cycle();
    chk("div_ov", bus.out_valid, 1);
    chk("div_result", bus.result, 14);
    chk("div_ready_back", bus.in_ready, 1);
    chk("div_carry", bus.carry, 0);

    // Accepted in the same cycle the divide result is reported.
    issue(OP_DIV, 8'd55, 8'd0);
    chk("div0_ov", bus.out_valid, 1);
    chk("div0_result", bus.result, 255);
    chk("div0_err", bus.div_err, 1);
    chk("div0_carry", bus.carry, 0);
    issue(OP_AND, 8'hF0, 8'h3C);
    chk("and_result", bus.result, 8'h30);
    chk("and_err_clr", bus.div_err, 0);

    issue(OP_ADD, 8'd4, 8'd6);
    chk("seed_result", bus.result, 10);
    issue(OP_MAC, 8'd3, 8'd4);
    chk("mac_result", bus.result, 22);
    chk("mac_carry", bus.carry, 0);
    issue(OP_ACC_MUL, 8'd12, 8'd0);
    chk("accmul_result", bus.result, 8);
    chk("accmul_carry", bus.carry, 1);
    issue(OP_ROL, 8'h81, 8'd0);
    chk("rol_result", bus.result, 8'h03);
    issue(OP_ROR, 8'h81, 8'd0);
    chk("ror_result", bus.result, 8'hC0);
    issue(OP_MUL, 8'd16, 8'd17);
    chk("mul_result", bus.result, 8'h10);
    chk("mul_carry", bus.carry, 1);
    issue(OP_LT, 8'd9, 8'd3);
    chk("lt_false", bus.result, 0);
    issue(OP_GT, 8'd9, 8'd3);
    chk("gt_result", bus.result, 8'hFF);
    chk("gt_zero", bus.zero, 0);

    // Reset during the 4th divider iteration aborts the divide.
    issue(OP_DIV, 8'd100, 8'd7);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_zero", bus.zero, 1);
    chk("mid_rst_ov", bus.out_valid, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      idle_cycle();
      chk($sformatf("post_rst_ov%0d", k), bus.out_valid, 0);
    end
    chk("post_rst_result", bus.result, 0);
    issue(OP_EQ, 8'd7, 8'd7);
    chk("eq_ov", bus.out_valid, 1);
    chk("eq_result", bus.result, 8'hFF);
    chk("eq_zero", bus.zero, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
